dtc_rr_sched: RTL and testbench

DTC_RR_SCHED -- requirements
Module: dtc_rr_sched

---
 rtl/dtc_rr_sched_pkg.sv | 13 +
 rtl/dtc_rr_arb.sv | 38 +++
 rtl/dtc_rr_sched.sv | 158 +++++++++++++++
 tb/tb_dtc_rr_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_rr_sched_pkg.sv
// Shared defaults and helpers for the round-robin classifier scheduler.
package dtc_rr_sched_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int FEAT_W_DEF = 11;
    localparam int CNT_W_DEF  = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dtc_rr_arb.sv
// Combinational round-robin arbiter: scans from ptr upward (wrapping) and
// grants the first active request. gnt is one-hot or all zero.
module dtc_rr_arb
    import dtc_rr_sched_pkg::*;
#(
    parameter  int N  = NREQ_DEF,
    localparam int PW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          gnt_en,
    output logic [N-1:0]  gnt
);

    int            idx;
    logic [PW-1:0] idx_w;
    logic          found;

    // Rotating priority scan; the first hit wins, later hits are masked.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = PW'(idx);
            if (gnt_en && !found && req[idx_w]) begin
                gnt[idx_w] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtc_rr_sched.sv
// Round-robin scheduler feeding one shared external classifier through a
// two-stage pipeline (S1 holds the sample, S2 holds the decision), with
// accepted-result statistics.
module dtc_rr_sched
    import dtc_rr_sched_pkg::*;
#(
    parameter  int NREQ   = NREQ_DEF,
    parameter  int FEAT_W = FEAT_W_DEF,
    parameter  int CNT_W  = CNT_W_DEF,
    localparam int ID_W   = id_w(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*FEAT_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [FEAT_W-1:0]        cls_inp,
    input  logic                     cls_outp,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_class,
    input  logic                     stat_clr,
    output logic [CNT_W-1:0]         tot_cnt,
    output logic [CNT_W-1:0]         pos_cnt,
    output logic                     busy
);

    // Saturating increment: a full counter stays full.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              vld_p1_q, vld_p1_d;
    logic              vld_p2_q, vld_p2_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [FEAT_W-1:0] inp_p1_q, inp_p1_d;
    logic [ID_W-1:0]   id_p1_q, id_p1_d;
    logic              cls_p2_q, cls_p2_d;
    logic [ID_W-1:0]   id_p2_q, id_p2_d;
    logic [CNT_W-1:0]  tot_q, tot_d;
    logic [CNT_W-1:0]  pos_q, pos_d;

    logic              adv1, adv2, gnt_en, any_gnt, acc;
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic [FEAT_W-1:0] gnt_data;

    // Stage advance conditions; grants are suppressed while rst is high.
    always_comb begin
        adv2   = !vld_p2_q | rsp_ready;
        adv1   = !vld_p1_q | adv2;
        gnt_en = en & adv1 & !rst;
    end

    dtc_rr_arb #(.N(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt_en (gnt_en),
        .gnt    (gnt)
    );

    assign any_gnt = |gnt;
    assign acc     = vld_p2_q & rsp_ready;

    // Encode the one-hot grant and select the winning sample.
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = ID_W'(i);
                gnt_data = req_data[i*FEAT_W +: FEAT_W];
            end
        end
    end

    // Next-state for pointer, both pipeline stages and the counters.
    always_comb begin
        ptr_d    = ptr_q;
        vld_p1_d = vld_p1_q;
        inp_p1_d = inp_p1_q;
        id_p1_d  = id_p1_q;
        vld_p2_d = vld_p2_q;
        cls_p2_d = cls_p2_q;
        id_p2_d  = id_p2_q;
        tot_d    = tot_q;
        pos_d    = pos_q;

        if (any_gnt) begin
            ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end

        // S1 refills from a grant, or empties; the sample itself is kept.
        if (adv1) begin
            vld_p1_d = any_gnt;
            if (any_gnt) begin
                inp_p1_d = gnt_data;
                id_p1_d  = gnt_idx;
            end
        end

        // S2 captures the classifier decision only for a valid S1 sample.
        if (adv2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                cls_p2_d = cls_outp;
                id_p2_d  = id_p1_q;
            end
        end

        if (stat_clr) begin
            tot_d = '0;
            pos_d = '0;
        end else if (acc) begin
            tot_d = sat_inc(tot_q);
            if (cls_p2_q) begin
                pos_d = sat_inc(pos_q);
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            vld_p1_q <= 1'b0;
            inp_p1_q <= '0;
            id_p1_q  <= '0;
            vld_p2_q <= 1'b0;
            cls_p2_q <= 1'b0;
            id_p2_q  <= '0;
            tot_q    <= '0;
            pos_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            vld_p1_q <= vld_p1_d;
            inp_p1_q <= inp_p1_d;
            id_p1_q  <= id_p1_d;
            vld_p2_q <= vld_p2_d;
            cls_p2_q <= cls_p2_d;
            id_p2_q  <= id_p2_d;
            tot_q    <= tot_d;
            pos_q    <= pos_d;
        end
    end

    assign req_ready = gnt;
    assign cls_inp   = inp_p1_q;
    assign rsp_valid = vld_p2_q;
    assign rsp_id    = id_p2_q;
    assign rsp_class = cls_p2_q;
    assign tot_cnt   = tot_q;
    assign pos_cnt   = pos_q;
    assign busy      = vld_p1_q | vld_p2_q;

endmodule

// File: tb/tb_dtc_rr_sched.sv
// Directed bench for dtc_rr_sched (4 requesters, 11-bit features, 4-bit counters).
module tb_dtc_rr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [43:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [10:0] cls_inp;
    logic        cls_outp;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic        rsp_class;
    logic        stat_clr = 1'b0;
    logic [3:0]  tot_cnt;
    logic [3:0]  pos_cnt;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Classifier model: positive when the feature MSB is clear.
    assign cls_outp = ~cls_inp[10];

    dtc_rr_sched #(.NREQ(4), .FEAT_W(11), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cls_inp(cls_inp), .cls_outp(cls_outp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_class(rsp_class), .stat_clr(stat_clr), .tot_cnt(tot_cnt),
        .pos_cnt(pos_cnt), .busy(busy)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic do_reset;
        next_cycle;
        rst = 1'b1; req_valid = '0; en = 1'b1; rsp_ready = 1'b1; stat_clr = 1'b0;
        next_cycle;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        next_cycle;
        rst = 1'b1; en = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
        sample;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (cls_inp !== 11'h000) begin n_fail++; $display("FAIL reset_cls_inp got %h want 000", cls_inp); end
        n_cmp++; if (rsp_id !== 2'd0 || rsp_class !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got id=%0d cls=%b want 0/0", rsp_id, rsp_class); end
        n_cmp++; if (tot_cnt !== 4'd0 || pos_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", tot_cnt, pos_cnt); end
        next_cycle;
        req_valid = '0; rst = 1'b0;
        sample;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL post_reset_idle got busy=%b rdy=%b want 0/0000", busy, req_ready); end
    endtask

    task automatic test_single;
        do_reset;
        next_cycle;
        req_valid = 4'b0001; req_data[10:0] = 11'h7FF; rsp_ready = 1'b1;
        sample;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_c0_valid got %b want 0", rsp_valid); end
        next_cycle;
        req_valid = '0;
        sample;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_c1 got v=%b busy=%b want 0/1", rsp_valid, busy); end
        n_cmp++; if (cls_inp !== 11'h7FF) begin n_fail++; $display("FAIL single_cls_inp got %h want 7ff", cls_inp); end
        next_cycle;
        sample;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_class !== 1'b0) begin n_fail++; $display("FAIL single_c2_rsp got v=%b id=%0d cls=%b want 1/0/0", rsp_valid, rsp_id, rsp_class); end
        next_cycle;
        sample;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_c3 got v=%b busy=%b want 0/0", rsp_valid, busy); end
        n_cmp++; if (tot_cnt !== 4'd1 || pos_cnt !== 4'd0) begin n_fail++; $display("FAIL single_cnt got %0d/%0d want 1/0", tot_cnt, pos_cnt); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_gnt;
        logic [10:0] exp_inp;
        logic        exp_v, exp_c;
        int          p, r;
        do_reset;
        for (int c = 0; c < 11; c++) begin
            next_cycle;
            rsp_ready = 1'b1;
            if (c < 8) begin
                req_valid = 4'b1111;
                for (int i = 0; i < 4; i++) req_data[i*11 +: 11] = {c[0], 10'(c*16 + i)};
            end else begin
                req_valid = 4'b0000;
            end
            sample;
            exp_gnt = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            n_cmp++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, exp_gnt); end
            if (c >= 1 && c <= 8) begin
                p = c - 1;
                exp_inp = {p[0], 10'(p*16 + p % 4)};
                n_cmp++; if (cls_inp !== exp_inp) begin n_fail++; $display("FAIL rr_cls_inp c=%0d got %h want %h", c, cls_inp, exp_inp); end
            end
            exp_v = (c >= 2 && c < 10);
            n_cmp++; if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL rr_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_v); end
            if (exp_v) begin
                r = c - 2;
                exp_c = ~r[0];
                n_cmp++; if (rsp_id !== 2'(r % 4) || rsp_class !== exp_c) begin n_fail++; $display("FAIL rr_rsp c=%0d got id=%0d cls=%b want %0d/%b", c, rsp_id, rsp_class, r % 4, exp_c); end
            end
        end
        n_cmp++; if (tot_cnt !== 4'd8 || pos_cnt !== 4'd4) begin n_fail++; $display("FAIL rr_cnt got %0d/%0d want 8/4", tot_cnt, pos_cnt); end
    endtask

    task automatic test_backpressure;
        logic [3:0] rv_t [9];
        logic       rr_t [9];
        logic [3:0] gnt_t [9];
        logic       v_t [9];
        logic [1:0] id_t [9];
        logic       cls_t [9];
        rv_t  = '{4'b0011, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        rr_t  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        gnt_t = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        v_t   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        id_t  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        cls_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset;
        req_data[0*11 +: 11] = 11'h400;
        req_data[1*11 +: 11] = 11'h001;
        req_data[2*11 +: 11] = 11'h123;
        for (int c = 0; c < 9; c++) begin
            next_cycle;
            req_valid = rv_t[c]; rsp_ready = rr_t[c];
            sample;
            n_cmp++; if (req_ready !== gnt_t[c]) begin n_fail++; $display("FAIL bp_grant c=%0d got %b want %b", c, req_ready, gnt_t[c]); end
            n_cmp++; if (rsp_valid !== v_t[c]) begin n_fail++; $display("FAIL bp_rsp_valid c=%0d got %b want %b", c, rsp_valid, v_t[c]); end
            if (v_t[c]) begin
                n_cmp++; if (rsp_id !== id_t[c] || rsp_class !== cls_t[c]) begin n_fail++; $display("FAIL bp_rsp c=%0d got id=%0d cls=%b want %0d/%b", c, rsp_id, rsp_class, id_t[c], cls_t[c]); end
            end
            if (c >= 2 && c <= 4) begin
                n_cmp++; if (busy !== 1'b1 || cls_inp !== 11'h001) begin n_fail++; $display("FAIL bp_hold c=%0d got busy=%b inp=%h want 1/001", c, busy, cls_inp); end
            end
        end
        n_cmp++; if (tot_cnt !== 4'd3 || pos_cnt !== 4'd2) begin n_fail++; $display("FAIL bp_cnt got %0d/%0d want 3/2", tot_cnt, pos_cnt); end
    endtask

    task automatic test_en_drain;
        logic       en_t [5];
        logic [3:0] rv_t [5];
        logic [3:0] gnt_t [5];
        logic       v_t [5];
        logic [1:0] id_t [5];
        logic       cls_t [5];
        logic       busy_t [5];
        en_t   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rv_t   = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
        gnt_t  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        v_t    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        id_t   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        cls_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        busy_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset;
        req_data[0*11 +: 11] = 11'h005;
        req_data[1*11 +: 11] = 11'h7F0;
        req_data[2*11 +: 11] = 11'h0AA;
        for (int c = 0; c < 5; c++) begin
            next_cycle;
            en = en_t[c]; req_valid = rv_t[c]; rsp_ready = 1'b1;
            sample;
            n_cmp++; if (req_ready !== gnt_t[c]) begin n_fail++; $display("FAIL en_grant c=%0d got %b want %b", c, req_ready, gnt_t[c]); end
            n_cmp++; if (rsp_valid !== v_t[c] || busy !== busy_t[c]) begin n_fail++; $display("FAIL en_state c=%0d got v=%b busy=%b want %b/%b", c, rsp_valid, busy, v_t[c], busy_t[c]); end
            if (v_t[c]) begin
                n_cmp++; if (rsp_id !== id_t[c] || rsp_class !== cls_t[c]) begin n_fail++; $display("FAIL en_rsp c=%0d got id=%0d cls=%b want %0d/%b", c, rsp_id, rsp_class, id_t[c], cls_t[c]); end
            end
        end
        next_cycle;
        req_valid = '0; en = 1'b1;
    endtask

    task automatic test_saturation;
        do_reset;
        req_data[0*11 +: 11] = 11'h001;
        for (int c = 0; c < 24; c++) begin
            next_cycle;
            req_valid = (c < 20) ? 4'b0001 : 4'b0000; rsp_ready = 1'b1;
            sample;
            if (c == 12) begin
                n_cmp++; if (tot_cnt !== 4'd10 || pos_cnt !== 4'd10) begin n_fail++; $display("FAIL sat_mid_cnt got %0d/%0d want 10/10", tot_cnt, pos_cnt); end
            end
        end
        n_cmp++; if (tot_cnt !== 4'd15 || pos_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt got %0d/%0d want 15/15", tot_cnt, pos_cnt); end
        next_cycle;
        req_valid = 4'b0001;
        next_cycle;
        req_valid = 4'b0000;
        next_cycle;
        stat_clr = 1'b1;
        sample;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sat_clr_accept_valid got %b want 1", rsp_valid); end
        next_cycle;
        stat_clr = 1'b0;
        sample;
        n_cmp++; if (tot_cnt !== 4'd0 || pos_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr_wins got %0d/%0d want 0/0", tot_cnt, pos_cnt); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        req_data[0*11 +: 11] = 11'h111;
        req_data[1*11 +: 11] = 11'h222;
        next_cycle;
        req_valid = 4'b0011; rsp_ready = 1'b0;
        sample;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_grant0 got %b want 0001", req_ready); end
        next_cycle;
        req_valid = 4'b0010;
        sample;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_grant1 got %b want 0010", req_ready); end
        next_cycle;
        req_valid = 4'b0000;
        sample;
        n_cmp++; if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_class !== 1'b1) begin n_fail++; $display("FAIL rm_full got v=%b busy=%b cls=%b want 1/1/1", rsp_valid, busy, rsp_class); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_class !== 1'b0) begin n_fail++; $display("FAIL rm_async_clear got v=%b busy=%b cls=%b want 0/0/0", rsp_valid, busy, rsp_class); end
        n_cmp++; if (cls_inp !== 11'h000 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL rm_async_data got inp=%h id=%0d want 000/0", cls_inp, rsp_id); end
        next_cycle;
        rst = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
        sample;
        n_cmp++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_restart got rdy=%b v=%b want 0001/0", req_ready, rsp_valid); end
        next_cycle;
        req_valid = 4'b0000;
        sample;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_stray got %b want 0", rsp_valid); end
        next_cycle;
        sample;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_class !== 1'b1) begin n_fail++; $display("FAIL rm_first_rsp got v=%b id=%0d cls=%b want 1/0/1", rsp_valid, rsp_id, rsp_class); end
        next_cycle;
        sample;
        n_cmp++; if (rsp_valid !== 1'b0 || tot_cnt !== 4'd1) begin n_fail++; $display("FAIL rm_after got v=%b tot=%0d want 0/1", rsp_valid, tot_cnt); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_en_drain;
        test_saturation;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
